// File: rtl/dac_playback_pkg.sv
// Shared types and constants for the DAC playback block.
package dac_playback_pkg;

  typedef enum logic [1:0] {IDLE, FILL, PLAY} state_t;

  // Default geometry: two 16-bit samples per stream beat, 16-entry sample FIFO.
  localparam int SAMPLE_W          = 16;
  localparam int SAMPLE_FIFO_DEPTH = 16;
  localparam int BEAT_W            = 2 * SAMPLE_W;
  localparam int FIFO_CNT_W        = $clog2(SAMPLE_FIFO_DEPTH) + 1;

  // Same derivations for non-default parameterisations.
  function automatic int beat_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Sample FIFO: writes one or two samples per cycle (low half first),
// reads one sample per cycle, first-word fall-through read data.
module dac_sample_fifo
  import dac_playback_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = SAMPLE_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic                  wr_two,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;

  // Storage write; the caller only writes when at least two entries are free.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wptr] <= wr_data[DATA_W-1:0];
      if (wr_two) mem[wptr + AW'(1)] <= wr_data[2*DATA_W-1:DATA_W];
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (wr_two ? AW'(2) : AW'(1));
      if (rd_en) rptr <= rptr + AW'(1);
      count <= count + (wr_en ? (wr_two ? CW'(2) : CW'(1)) : CW'(0))
                     - (rd_en ? CW'(1) : CW'(0));
    end
  end

  assign rd_data = mem[rptr];

endmodule

// File: rtl/dac_playback.sv
// DAC playback: prefill a sample FIFO from an AXI-Stream source, then replay
// packet_size samples every clk_div+1 cycles on a parallel DAC bus.
// Optional macro DAC_PLAYBACK_TLAST_CHECK_EN adds a sticky tlast_err output.
module dac_playback
  import dac_playback_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = SAMPLE_FIFO_DEPTH,
  parameter int CNT_W      = 32,
  parameter int DIV_W      = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic [CNT_W-1:0]    packet_size,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [2*DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [DATA_W-1:0]   dac_data,
  output logic                dac_valid,
  output logic                busy,
  output logic                done,
`ifdef DAC_PLAYBACK_TLAST_CHECK_EN
  output logic                tlast_err,
`endif
  output logic                underrun
);
  localparam int BW  = (DATA_W == SAMPLE_W) ? BEAT_W : beat_w(DATA_W);
  localparam int FCW = (FIFO_DEPTH == SAMPLE_FIFO_DEPTH) ? FIFO_CNT_W : fifo_cnt_w(FIFO_DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  size_q, beats_left, smp_cnt;
  logic [DIV_W-1:0]  div_q, div_cnt;
  logic [FCW-1:0]    fifo_cnt;
  logic [DATA_W-1:0] fifo_rd;
  logic              start_acc, beat_acc, fill_ok, tick, pop, flush, wr_two;

  assign start_acc = (state == IDLE) && start && !stop && (packet_size != '0);
  // A stop cycle never accepts a beat: it would only be flushed.
  assign s_axis_tready = (state == FILL || state == PLAY) && !stop &&
                         (FCW'(FIFO_DEPTH) - fifo_cnt >= FCW'(2)) && (beats_left != '0);
  assign beat_acc = s_axis_tvalid && s_axis_tready;
  assign wr_two   = !((beats_left == CNT_W'(1)) && size_q[0]);
  assign fill_ok  = (fifo_cnt >= FCW'(FIFO_DEPTH - 1)) || (beats_left == '0);
  assign tick     = (state == PLAY) && !stop && (div_cnt == '0);
  assign pop      = tick && (fifo_cnt != '0);
  assign flush    = start_acc || (stop && state != IDLE);
  assign busy     = (state != IDLE);

  dac_sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (flush),
    .wr_en   (beat_acc),
    .wr_two  (wr_two),
    .wr_data (s_axis_tdata[BW-1:0]),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_cnt)
  );

  // Control FSM with pacing divider, sample counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      size_q     <= '0;
      div_q      <= '0;
      beats_left <= '0;
      smp_cnt    <= '0;
      div_cnt    <= '0;
      dac_data   <= '0;
      dac_valid  <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dac_valid <= 1'b0;
      done      <= 1'b0;
      if (beat_acc) beats_left <= beats_left - CNT_W'(1);
      case (state)
        IDLE: if (start_acc) begin
          size_q     <= packet_size;
          div_q      <= clk_div;
          beats_left <= (packet_size >> 1) + CNT_W'(packet_size[0]);
          smp_cnt    <= '0;
          underrun   <= 1'b0;
          state      <= FILL;
        end
        FILL: begin
          if (stop) state <= IDLE;
          else if (fill_ok) begin
            div_cnt <= '0;
            state   <= PLAY;
          end
        end
        PLAY: begin
          if (stop) state <= IDLE;
          else if (tick) begin
            if (pop) begin
              dac_data  <= fifo_rd;
              dac_valid <= 1'b1;
              smp_cnt   <= smp_cnt + CNT_W'(1);
              div_cnt   <= div_q;
              if (smp_cnt + CNT_W'(1) == size_q) begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              // Empty FIFO: retry next cycle without reloading the divider.
              underrun <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DAC_PLAYBACK_TLAST_CHECK_EN
  // Sticky framing error: tlast must appear on the final beat and only there.
  always_ff @(posedge clk) begin
    if (!resetn || start_acc) tlast_err <= 1'b0;
    else if (beat_acc && (s_axis_tlast != (beats_left == CNT_W'(1)))) tlast_err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

endmodule

// File: tb/tb_dac_playback.sv
// Self-checking bench for dac_playback: expected sample queue, pacing rule
// and completion rule checked every cycle against the DUT outputs.
module tb_dac_playback;
  localparam int DATA_W = 16, FIFO_DEPTH = 16, CNT_W = 32, DIV_W = 16;
  localparam int BUDGET = 4000;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, stop = 1'b0;
  logic [CNT_W-1:0]    packet_size = '0;
  logic [DIV_W-1:0]    clk_div = '0;
  logic [2*DATA_W-1:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
  logic s_axis_tready, dac_valid, busy, done, underrun;
  logic [DATA_W-1:0] dac_data;
`ifdef DAC_PLAYBACK_TLAST_CHECK_EN
  logic tlast_err;
`endif

  dac_playback #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .packet_size(packet_size), .clk_div(clk_div),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .dac_data(dac_data), .dac_valid(dac_valid), .busy(busy), .done(done),
`ifdef DAC_PLAYBACK_TLAST_CHECK_EN
    .tlast_err(tlast_err),
`endif
    .underrun(underrun));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_last = '0, e_cmp;
  bit m_active = 0, chk_en = 0, uniform = 0, abort = 0;
  int strobes = 0, cur_size = 0, cur_div = 0, cur_nb = 0, beats_sent = 0, last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle compare against the model: data order, pacing, done, busy, tready.
  always @(negedge clk) if (chk_en) begin
    if (dac_valid) begin
      if (!m_active || exp_q.size() == 0) chk("spurious_strobe", 1, 0);
      else begin
        e_cmp = exp_q.pop_front();
        strobes++;
        chk("strobe_data", dac_data, e_cmp);
        if (uniform && strobes > 1) chk("strobe_interval", cyc - last_cyc, cur_div + 1);
        last_cyc = cyc;
        m_last = e_cmp;
        chk("done_on_last", done, strobes == cur_size);
        if (strobes == cur_size) m_active = 0;
      end
    end else begin
      chk("done_without_strobe", done, 0);
      chk("data_hold", dac_data, m_last);
    end
    chk("busy", busy, m_active);
    if (!m_active || beats_sent >= cur_nb) chk("tready_low", s_axis_tready, 0);
  end

  // act: 0 none, 1 stop, 2 re-pulse start, 3 reset -- after act_at strobes.
  // vmode: 0 tvalid always, 1 one cycle in four, 2 random. ul: expected underrun or -1.
  task automatic run(input int size, input int div, input int vmode, input int act,
                     input int act_at, input int tl_beat, input bit rnd, input int ul);
    logic [DATA_W-1:0]   smp[$];
    logic [2*DATA_W-1:0] bq[$];
    int nb, t;
    bit acted, xfer_l;
    nb = (size + 1) / 2;
    for (int i = 0; i < size; i++) smp.push_back(rnd ? DATA_W'($urandom) : DATA_W'(i));
    if (size % 2 == 1) smp.push_back(16'hBEEF);
    for (int b = 0; b < nb; b++) bq.push_back({smp[2*b+1], smp[2*b]});
    exp_q.delete();
    for (int i = 0; i < size; i++) exp_q.push_back(smp[i]);
    strobes = 0; cur_size = size; cur_div = div; cur_nb = nb; beats_sent = 0;
    abort = 0; acted = 0; uniform = (vmode == 0);
    @(negedge clk); packet_size = CNT_W'(size); clk_div = DIV_W'(div); start = 1'b1;
    @(posedge clk); m_active = (size != 0);
    @(negedge clk); start = 1'b0;
    if (size == 0) begin
      repeat (6) @(posedge clk);
      chk("zero_size_idle", busy, 0);
      return;
    end
    fork
      begin : drv
        int b;
        b = 0;
        while (b < nb && !abort) begin
          @(negedge clk);
          s_axis_tdata  = bq[b];
          s_axis_tlast  = (b + 1 == tl_beat);
          s_axis_tvalid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 4 == 0) : 1'($urandom % 2);
          #1;
          xfer_l = s_axis_tvalid && s_axis_tready;
          @(posedge clk);
          if (xfer_l) begin b++; beats_sent = b; end
        end
        @(negedge clk); s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      end
      begin : ctl
        t = 0;
        while (m_active && t < BUDGET) begin
          @(posedge clk); t++;
          if (act != 0 && !acted && strobes == act_at) begin
            acted = 1;
            @(negedge clk);
            case (act)
              1: stop = 1'b1;
              2: begin packet_size = CNT_W'(4); clk_div = '0; start = 1'b1; end
              default: resetn = 1'b0;
            endcase
            @(posedge clk);
            if (act != 2) begin m_active = 0; abort = 1; end
            if (act == 3) m_last = '0;
            @(negedge clk);
            stop = 1'b0; start = 1'b0;
            if (act == 3) begin
              chk("rst_dac_data", dac_data, 0);
              chk("rst_dac_valid", dac_valid, 0);
              chk("rst_busy", busy, 0);
              chk("rst_done", done, 0);
              chk("rst_underrun", underrun, 0);
              chk("rst_tready", s_axis_tready, 0);
              resetn = 1'b1;
            end
          end
        end
        if (t >= BUDGET) begin
          chk("timeout", 1, 0);
          abort = 1; m_active = 0;
          @(negedge clk) resetn = 1'b0;
          @(posedge clk) m_last = '0;
          @(negedge clk) resetn = 1'b1;
        end
      end
    join
    repeat (3) @(posedge clk);
    if (act == 0 || act == 2) chk("strobe_count", strobes, size);
    if (ul >= 0) chk("underrun", underrun, ul);
`ifdef DAC_PLAYBACK_TLAST_CHECK_EN
    chk("tlast_err", tlast_err, (tl_beat != nb) && act != 3);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dac_data", dac_data, 0);
    chk("reset_dac_valid", dac_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_underrun", underrun, 0);
    chk("reset_tready", s_axis_tready, 0);
    resetn = 1'b1;
    chk_en = 1;

    // Paced playback, 4 cycles per sample.
    run(8, 3, 0, 0, 0, 4, 0, 0);
    chk("t1_final_sample", dac_data, 7);
    chk("t1_strobes", strobes, 8);
    // Odd length, one sample per cycle; BEEF must never play.
    run(5, 0, 0, 0, 0, 3, 0, 0);
    chk("t2_final_sample", dac_data, 4);
    // Starved source at full rate.
    run(64, 0, 1, 0, 0, 32, 0, 1);
    chk("t3_final_sample", dac_data, 63);
    // Abort after 10 strobes, then a fresh short packet.
    run(100, 3, 0, 1, 10, 50, 0, 0);
    chk("t4_stop_strobes", strobes, 10);
    chk("t4_stop_hold", dac_data, 9);
    run(4, 0, 0, 0, 0, 2, 0, 0);
    chk("t4_fresh_final", dac_data, 3);
    // Zero-length start, start+stop together, start while busy, reset mid-play.
    run(0, 0, 0, 0, 0, 0, 0, -1);
    @(negedge clk); packet_size = CNT_W'(4); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (4) @(posedge clk);
    chk("start_stop_idle", busy, 0);
    run(16, 2, 0, 2, 3, 8, 1, 0);
    run(32, 1, 0, 3, 5, 16, 1, -1);
    run(6, 0, 0, 0, 0, 3, 0, 0);
    chk("t5_fresh_final", dac_data, 5);
    // Framing: tlast on beat 2 only, then correctly on beat 4.
    run(8, 0, 0, 0, 0, 2, 1, 0);
    run(8, 0, 0, 0, 0, 4, 1, 0);
    // Randomised packets.
    for (int k = 0; k < 10; k++) begin
      int sz, dv, vm;
      sz = $urandom_range(1, 40);
      dv = $urandom_range(0, 4);
      vm = $urandom_range(0, 2);
      run(sz, dv, vm, 0, 0, (sz + 1) / 2, 1, (vm == 0) ? 0 : -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
